// File: rtl/req_encoder32to5_pkg.sv
// Shared widths, state encoding and mask helpers for the 32-line request encoder.
package req_encoder32to5_pkg;

  localparam int NUM_LINES = 32;
  localparam int CODE_W    = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_t;

  // Two or more bits set: clearing the lowest set bit still leaves something.
  function automatic logic multi_hot(input logic [NUM_LINES-1:0] mask);
    return (mask & (mask - NUM_LINES'(1))) != '0;
  endfunction

endpackage

// File: rtl/req_encoder32to5_prienc.sv
// Combinational priority encoder: 32-bit mask to 5-bit index plus any-bit flag.
module prienc32to5
  import req_encoder32to5_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic [NUM_LINES-1:0] mask,
  output logic [CODE_W-1:0]    idx,
  output logic                 any
);

  always_comb begin
    idx = '0;
    any = |mask;
    // Later hits overwrite earlier ones, so scan direction picks the winner.
    if (MSB_FIRST) begin
      for (int i = 0; i < NUM_LINES; i++)
        if (mask[i]) idx = CODE_W'(i);
    end else begin
      for (int i = NUM_LINES - 1; i >= 0; i--)
        if (mask[i]) idx = CODE_W'(i);
    end
  end

endmodule

// File: rtl/req_encoder32to5.sv
// Captures a multi-hot request mask and presents one set index per ack, in priority order.
module req_encoder32to5
  import req_encoder32to5_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                 clock,
  input  logic                 clear,
  input  logic [NUM_LINES-1:0] req,
  input  logic                 load,
  input  logic                 ack,
  output logic [CODE_W-1:0]    code,
  output logic                 valid,
  output logic                 busy,
  output logic                 multi,
  output logic                 none
);

  state_t               state_p1;
  logic [NUM_LINES-1:0] pending_p1;
  logic [NUM_LINES-1:0] pend_nxt;
  logic [CODE_W-1:0]    nxt_idx;
  logic                 nxt_any;

  // Next-pending feeds the single encoder, so the new code lands on the same edge.
  always_comb begin
    pend_nxt = pending_p1;
    if (state_p1 == IDLE) begin
      if (load) pend_nxt = req;
    end else if (ack && valid) begin
      pend_nxt = pending_p1 & ~(NUM_LINES'(1) << code);
    end
  end

  prienc32to5 #(
    .MSB_FIRST(MSB_FIRST)
  ) u_prienc (
    .mask(pend_nxt),
    .idx (nxt_idx),
    .any (nxt_any)
  );

  // Stage p1: state and registered outputs
  always_ff @(posedge clock) begin
    if (!clear) begin
      state_p1   <= IDLE;
      pending_p1 <= '0;
      code       <= '0;
      valid      <= 1'b0;
      busy       <= 1'b0;
      multi      <= 1'b0;
      none       <= 1'b0;
    end else begin
      case (state_p1)
        IDLE: begin
          none <= 1'b0;
          if (load) begin
            if (nxt_any) begin
              pending_p1 <= pend_nxt;
              state_p1   <= SERVE;
              busy       <= 1'b1;
              valid      <= 1'b1;
              code       <= nxt_idx;
              multi      <= multi_hot(req);
            end else begin
              none <= 1'b1;
            end
          end
        end
        SERVE: begin
          none <= 1'b0;
          if (ack && valid) begin
            pending_p1 <= pend_nxt;
            if (nxt_any) begin
              code <= nxt_idx;
            end else begin
              code     <= '0;
              valid    <= 1'b0;
              busy     <= 1'b0;
              multi    <= 1'b0;
              state_p1 <= IDLE;
            end
          end
        end
        default: state_p1 <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_req_encoder32to5.sv
// Directed bench driving an MSB-first and an LSB-first encoder from the same stimulus.
module tb_req_encoder32to5;

  logic        clock = 1'b0;
  logic        clear;
  logic [31:0] req;
  logic        load;
  logic        ack;

  logic [4:0] code_m, code_l;
  logic       valid_m, valid_l, busy_m, busy_l, multi_m, multi_l, none_m, none_l;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  req_encoder32to5 #(.MSB_FIRST(1'b1)) u_msb (
    .clock(clock), .clear(clear), .req(req), .load(load), .ack(ack),
    .code(code_m), .valid(valid_m), .busy(busy_m), .multi(multi_m), .none(none_m)
  );

  req_encoder32to5 #(.MSB_FIRST(1'b0)) u_lsb (
    .clock(clock), .clear(clear), .req(req), .load(load), .ack(ack),
    .code(code_l), .valid(valid_l), .busy(busy_l), .multi(multi_l), .none(none_l)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    clear = 1'b0; req = '0; load = 1'b0; ack = 1'b0;
    tick(); tick();
    check("rst_code", {27'd0, code_m}, 0);
    check("rst_valid", {31'd0, valid_m}, 0);
    check("rst_busy", {31'd0, busy_m}, 0);
    check("rst_multi", {31'd0, multi_m}, 0);
    check("rst_none", {31'd0, none_m}, 0);
    clear = 1'b1;

    // single request
    req = 32'h0000_0001; load = 1'b1; tick(); load = 1'b0;
    check("one_code", {27'd0, code_m}, 0);
    check("one_valid", {31'd0, valid_m}, 1);
    check("one_busy", {31'd0, busy_m}, 1);
    check("one_multi", {31'd0, multi_m}, 0);
    ack = 1'b1; tick(); ack = 1'b0;
    check("one_done_valid", {31'd0, valid_m}, 0);
    check("one_done_busy", {31'd0, busy_m}, 0);

    // three bits, both priority orders
    req = 32'h8000_0005; load = 1'b1; tick(); load = 1'b0;
    check("tri_m0", {27'd0, code_m}, 31);
    check("tri_l0", {27'd0, code_l}, 0);
    check("tri_multi0", {31'd0, multi_m}, 1);
    ack = 1'b1; tick();
    check("tri_m1", {27'd0, code_m}, 2);
    check("tri_l1", {27'd0, code_l}, 2);
    check("tri_multi1", {31'd0, multi_l}, 1);
    tick();
    check("tri_m2", {27'd0, code_m}, 0);
    check("tri_l2", {27'd0, code_l}, 31);
    check("tri_valid2", {31'd0, valid_m}, 1);
    tick(); ack = 1'b0;
    check("tri_end_valid_m", {31'd0, valid_m}, 0);
    check("tri_end_valid_l", {31'd0, valid_l}, 0);
    check("tri_end_busy", {31'd0, busy_m}, 0);
    check("tri_end_multi", {31'd0, multi_m}, 0);

    // empty load
    req = '0; load = 1'b1; tick(); load = 1'b0;
    check("none_pulse", {31'd0, none_m}, 1);
    check("none_valid", {31'd0, valid_m}, 0);
    tick();
    check("none_clear", {31'd0, none_m}, 0);

    // ack while idle is ignored
    ack = 1'b1; tick(); ack = 1'b0;
    check("idle_ack_valid", {31'd0, valid_m}, 0);
    check("idle_ack_busy", {31'd0, busy_m}, 0);

    // load during SERVE ignored, with and without ack
    req = 32'h0000_0030; load = 1'b1; tick();
    check("srv_m0", {27'd0, code_m}, 5);
    req = 32'hFFFF_FFFF; tick();
    check("srv_hold_m", {27'd0, code_m}, 5);
    check("srv_hold_l", {27'd0, code_l}, 4);
    check("srv_hold_valid", {31'd0, valid_m}, 1);
    ack = 1'b1; tick();
    check("srv_ackload_m", {27'd0, code_m}, 4);
    check("srv_ackload_l", {27'd0, code_l}, 5);
    tick(); load = 1'b0; ack = 1'b0;
    check("srv_final_valid", {31'd0, valid_m}, 0);
    check("srv_final_busy", {31'd0, busy_l}, 0);
    tick();
    check("srv_after_valid", {31'd0, valid_m}, 0);

    // all 32 lines
    req = 32'hFFFF_FFFF; load = 1'b1; tick(); load = 1'b0; ack = 1'b1;
    for (int i = 0; i < 32; i++) begin
      check("all_m", {27'd0, code_m}, 31 - i);
      check("all_l", {27'd0, code_l}, i);
      check("all_valid", {31'd0, valid_m}, 1);
      tick();
    end
    ack = 1'b0;
    check("all_end_valid", {31'd0, valid_m}, 0);
    check("all_end_code", {27'd0, code_m}, 0);

    // reset mid-SERVE
    req = 32'h0000_00FF; load = 1'b1; tick(); load = 1'b0; ack = 1'b1;
    tick(); tick(); tick();
    check("mid_m", {27'd0, code_m}, 4);
    check("mid_l", {27'd0, code_l}, 3);
    clear = 1'b0; load = 1'b1; tick(); clear = 1'b1; ack = 1'b0;
    check("mid_rst_valid", {31'd0, valid_m}, 0);
    check("mid_rst_busy", {31'd0, busy_m}, 0);
    check("mid_rst_code", {27'd0, code_m}, 0);
    check("mid_rst_multi", {31'd0, multi_m}, 0);
    req = 32'h0000_0300; tick(); load = 1'b0;
    check("fresh_m0", {27'd0, code_m}, 9);
    check("fresh_l0", {27'd0, code_l}, 8);
    check("fresh_multi", {31'd0, multi_m}, 1);
    ack = 1'b1; tick();
    check("fresh_m1", {27'd0, code_m}, 8);
    check("fresh_l1", {27'd0, code_l}, 9);
    tick(); ack = 1'b0;
    check("fresh_end_valid", {31'd0, valid_m}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/req_encoder32to5.md
REQ_ENCODER32TO5 -- requirements
Module: req_encoder32to5

Interface
REQ-001 Parameter: MSB_FIRST, default 1, selects priority order: 1 = highest index served first, 0 = lowest index first.
REQ-002 Port: clock  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: clear  input  1  reset, synchronous, active-low; sampled on the rising edge of clock.
REQ-004 Port: req  input  32  request lines R31..R0; multi-hot allowed.
REQ-005 Port: load  input  1  capture req into the pending mask; honoured only in IDLE.
REQ-006 Port: ack  input  1  consumer accepted the presented code; honoured only while valid=1.
REQ-007 Port: code  output  5  binary index of the currently served request line.
REQ-008 Port: valid  output  1  code is meaningful.
REQ-009 Port: busy  output  1  block is in SERVE and ignores load.
REQ-010 Port: multi  output  1  the captured mask had two or more bits set.
REQ-011 Port: none  output  1  one-cycle pulse when load was seen in IDLE with req=0.

Function
REQ-012 Two states only: IDLE and SERVE. All outputs are registered.
REQ-013 IDLE, load=1, req!=0: at this edge pending<=req, state<=SERVE, busy<=1, valid<=1, code<=priority index of req, multi<=(popcount(req)>=2). Latency is one edge from load to valid.
REQ-014 IDLE, load=1, req=0: state stays IDLE; none<=1 for exactly one cycle; all other outputs are unchanged.
REQ-015 IDLE, load=0: none<=0; no other change.
REQ-016 SERVE, ack=1: clear pending[code].
  - If remaining pending!=0: code<=priority index of the remaining bits at the same edge; valid stays 1. One code is served per cycle back-to-back.
  - If remaining pending=0: valid<=0, busy<=0, multi<=0, code<=0, state<=IDLE.
REQ-017 SERVE, ack=0: code, valid and pending are held stable.
REQ-018 A load in SERVE is ignored; req changes after capture have no effect.
REQ-019 An ack while valid=0 is ignored.
REQ-020 Simultaneous load and ack in SERVE: ack is processed and load is ignored, even on the final ack.
REQ-021 A new capture is accepted no earlier than the first cycle after returning to IDLE.
REQ-022 Each captured bit is presented exactly once, in strict priority order. The number of valid cycles with ack equals popcount(req).
REQ-023 Priority index: MSB_FIRST=1 gives the highest set bit index; MSB_FIRST=0 gives the lowest set bit index. Index range is 0..31, 5 bits, with no wrap.

Reset
REQ-024 When clear=0 at a rising edge, the block sets: state IDLE, pending 0, code 0, valid 0, busy 0, multi 0, none 0.
REQ-025 Reset takes priority over load and ack, including mid-SERVE; the interrupted sequence is discarded.
REQ-026 Outputs are undefined only before the first clock edge with clear=0.

Structure
REQ-027 A shared package holds NUM_LINES=32, CODE_W=5 and the state encoding (IDLE=0, SERVE=1).
REQ-028 One combinational sub-module, prienc32to5, maps a 32-bit mask and MSB_FIRST to a 5-bit index plus an any-bit flag. The top instantiates it once on the next-pending value.
REQ-029 Popcount>=2 detection is implemented as mask & (mask-1) != 0; no full adder tree.

Verification
REQ-030 Reset, then load=1 with req=32'h0000_0001, then ack -> code=0, valid=1, multi=0 one edge after load; valid=0 and busy=0 one edge after ack.
REQ-031 MSB_FIRST=1, load with req=32'h8000_0005, ack held high -> codes 31, 2, 0 on consecutive cycles, multi=1 throughout, then IDLE.
REQ-032 MSB_FIRST=0 with the same req -> codes 0, 2, 31.
REQ-033 IDLE, load with req=0 -> none=1 for one cycle, valid stays 0. In SERVE, load with a new req plus ack=0 -> code unchanged, pending unchanged.
REQ-034 req=32'hFFFF_FFFF with continuous ack -> 32 valid cycles, codes 31 down to 0, then valid=0.
REQ-035 Mid-SERVE, after 3 of 8 bits served, clear=0 for one edge -> all outputs 0 next cycle. A subsequent load restarts from a fresh mask.
